// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Instruction-fetch bus between the program-counter sequencer and memory.
//   fetch_req   : request, high while the sequencer is fetching
//   fetch_addr  : fetch address, held stable until fetch_ready
//   fetch_ready : memory accepts the request
//   rdata_valid : fetched instruction has returned
// Modports: master (sequencer side), slave (memory side).
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
   parameter int WIDTH = 8
) ();
   logic             fetch_req;
   logic [WIDTH-1:0] fetch_addr;
   logic             fetch_ready;
   logic             rdata_valid;

   modport master (
      output fetch_req,
      output fetch_addr,
      input  fetch_ready,
      input  rdata_valid
   );

   modport slave (
      input  fetch_req,
      input  fetch_addr,
      output fetch_ready,
      output rdata_valid
   );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer: fetches one instruction at a time over the fetch
// bus, then in DECIDE picks the next pc (irq > jump > call > ret > increment).
// Calls and interrupts push the return address onto a small return stack.
//
// Optional feature macro: PC_SEQ_STACK_EN
//   defined   : return stack present, stack_err reports overflow/underflow
//   undefined : no stack; call acts as jump, irq jumps without push,
//               ret acts as increment, stack_err tied to 0
//
// Parameters: WIDTH (pc width), DEPTH (stack entries, power of two >= 2),
//             RESET_PC (pc after reset), IRQ_VEC (interrupt target)
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   run                   : start fetching from IDLE or HALT
//   halt_req              : enter HALT after the current instruction commits
//   bus                   : fetch bus (master side)
//   jump_req / jump_addr  : jump redirect
//   call_req / call_addr  : call redirect
//   ret_req               : return redirect
//   irq_req               : interrupt request
//   pc                    : current program counter
//   halted                : high in HALT
//   stack_err             : sticky stack overflow/underflow flag
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int               WIDTH    = 8,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter logic [WIDTH-1:0] IRQ_VEC  = WIDTH'(8'hF0)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 run,
   input  logic                 halt_req,
   pc_sequencer_if.master       bus,
   input  logic                 jump_req,
   input  logic [WIDTH-1:0]     jump_addr,
   input  logic                 call_req,
   input  logic [WIDTH-1:0]     call_addr,
   input  logic                 ret_req,
   input  logic                 irq_req,
   output logic [WIDTH-1:0]     pc,
   output logic                 halted,
   output logic                 stack_err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_DECIDE = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("pc_sequencer: DEPTH must be a power of two and at least 2");
   end

   logic [2:0]       state, state_nxt;
   logic [WIDTH-1:0] pc_q, pc_nxt, pc_inc;
   logic             decide;

   assign decide = (state == S_DECIDE);
   assign pc_inc = pc_q + WIDTH'(1);   // wraps all-ones to zero

`ifdef PC_SEQ_STACK_EN
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] stack_mem [DEPTH];
   logic [AW:0]      sp;               // number of valid entries, 0..DEPTH
   logic             stack_empty, stack_full;
   logic [WIDTH-1:0] stack_top;
   logic             want_push, want_pop, err_set, stack_err_q;

   assign stack_empty = (sp == '0);
   assign stack_full  = (sp == (AW+1)'(DEPTH));
   assign stack_top   = stack_mem[sp[AW-1:0] - AW'(1)];
`endif

   // Next-state logic.
   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_HALT: if (run)             state_nxt = S_FETCH;
         S_FETCH:        if (bus.fetch_ready) state_nxt = S_WAIT;
         S_WAIT:         if (bus.rdata_valid) state_nxt = S_DECIDE;
         S_DECIDE:       state_nxt = halt_req ? S_HALT : S_FETCH;
         default:        state_nxt = S_IDLE;
      endcase
   end

   // Redirect selection; only consumed while in DECIDE.
   always_comb begin
      pc_nxt = pc_inc;
`ifdef PC_SEQ_STACK_EN
      want_push = 1'b0;
      want_pop  = 1'b0;
      err_set   = 1'b0;
`endif
      if (irq_req) begin
         pc_nxt = IRQ_VEC;
`ifdef PC_SEQ_STACK_EN
         want_push = 1'b1;
`endif
      end else if (jump_req) begin
         pc_nxt = jump_addr;
      end else if (call_req) begin
         pc_nxt = call_addr;
`ifdef PC_SEQ_STACK_EN
         want_push = 1'b1;
`endif
      end else if (ret_req) begin
`ifdef PC_SEQ_STACK_EN
         if (stack_empty) begin
            pc_nxt  = pc_inc;   // underflow: fall through to the next instruction
            err_set = 1'b1;
         end else begin
            pc_nxt   = stack_top;
            want_pop = 1'b1;
         end
`else
         pc_nxt = pc_inc;
`endif
      end
`ifdef PC_SEQ_STACK_EN
      // Overflow drops the push but the redirect above is still taken.
      if (want_push && stack_full) err_set = 1'b1;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         pc_q  <= RESET_PC;
      end else begin
         state <= state_nxt;
         if (decide) pc_q <= pc_nxt;
      end
   end

`ifdef PC_SEQ_STACK_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sp          <= '0;
         stack_err_q <= 1'b0;
      end else if (decide) begin
         if (want_push && !stack_full) sp <= sp + (AW+1)'(1);
         else if (want_pop)            sp <= sp - (AW+1)'(1);
         if (err_set) stack_err_q <= 1'b1;
      end
   end

   // NOTE: stack storage has no reset; sp alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (decide && want_push && !stack_full)
         stack_mem[sp[AW-1:0]] <= pc_inc;
   end

   assign stack_err = stack_err_q;
`else
   assign stack_err = 1'b0;
`endif

   assign bus.fetch_req  = (state == S_FETCH);
   assign bus.fetch_addr = pc_q;
   assign pc             = pc_q;
   assign halted         = (state == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed self-checking bench for pc_sequencer (WIDTH=8, DEPTH=4).
// Expected values depend on whether PC_SEQ_STACK_EN is defined.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

`ifdef PC_SEQ_STACK_EN
   localparam bit STACK_EN = 1'b1;
`else
   localparam bit STACK_EN = 1'b0;
`endif

   logic       clk;
   logic       reset_n;
   logic       run, halt_req;
   logic       jump_req, call_req, ret_req, irq_req;
   logic [7:0] jump_addr, call_addr;
   logic [7:0] pc;
   logic       halted, stack_err;

   int errors = 0;
   int checks = 0;

   pc_sequencer_if #(.WIDTH(8)) bus ();

   pc_sequencer #(
      .WIDTH    (8),
      .DEPTH    (4),
      .RESET_PC (8'h00),
      .IRQ_VEC  (8'hF0)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .run       (run),
      .halt_req  (halt_req),
      .bus       (bus),
      .jump_req  (jump_req),
      .jump_addr (jump_addr),
      .call_req  (call_req),
      .call_addr (call_addr),
      .ret_req   (ret_req),
      .irq_req   (irq_req),
      .pc        (pc),
      .halted    (halted),
      .stack_err (stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic clear_redirects();
      jump_req  = 1'b0;
      call_req  = 1'b0;
      ret_req   = 1'b0;
      irq_req   = 1'b0;
      jump_addr = 8'h00;
      call_addr = 8'h00;
   endtask

   // Advance until fetch_req is seen (sampled 1 time unit after each edge).
   task automatic wait_fetch(output logic [7:0] addr, output int cycles);
      bit found;
      found  = 1'b0;
      cycles = 0;
      addr   = 8'hxx;
      for (int i = 0; i < 16 && !found; i++) begin
         @(posedge clk);
         #1;
         cycles++;
         if (bus.fetch_req === 1'b1) begin
            found = 1'b1;
            addr  = bus.fetch_addr;
         end
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL fetch_timeout: no fetch_req within 16 cycles");
      end
   endtask

   // Hold the given redirects for one instruction and return the next fetch address.
   task automatic next_fetch(input logic i_irq, input logic i_jump, input logic [7:0] ja,
                             input logic i_call, input logic [7:0] ca, input logic i_ret,
                             output logic [7:0] addr);
      int cyc;
      irq_req   = i_irq;
      jump_req  = i_jump;
      jump_addr = ja;
      call_req  = i_call;
      call_addr = ca;
      ret_req   = i_ret;
      wait_fetch(addr, cyc);
      clear_redirects();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      run = 1'b0;
      halt_req = 1'b0;
      bus.fetch_ready = 1'b1;
      bus.rdata_valid = 1'b1;
      clear_redirects();
      #3;
      checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc); end
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL reset_fetch_req: got %b want 0", bus.fetch_req); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
      checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_stack_err: got %b want 0", stack_err); end
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL idle_no_run: fetch_req got %b want 0", bus.fetch_req); end
   endtask

   task automatic test_sequential();
      logic [7:0] a;
      int         c;
      run = 1'b1;
      wait_fetch(a, c);
      run = 1'b0;
      checks++; if (a !== 8'h00) begin errors++; $display("FAIL seq_first: got %h want 00", a); end
      for (int i = 1; i <= 3; i++) begin
         wait_fetch(a, c);
         checks++; if (a !== 8'(i)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, a, 8'(i)); end
         checks++; if (c !== 3) begin errors++; $display("FAIL seq_period%0d: got %0d cycles want 3", i, c); end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] a;
      next_fetch(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, a);
      checks++; if (a !== 8'hFF) begin errors++; $display("FAIL wrap_jump: got %h want ff", a); end
      next_fetch(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, a);
      checks++; if (a !== 8'h00) begin errors++; $display("FAIL wrap_zero: got %h want 00", a); end
   endtask

   task automatic test_call_ret();
      logic [7:0] a;
      next_fetch(1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, a);
      checks++; if (a !== 8'h10) begin errors++; $display("FAIL cr_setup: got %h want 10", a); end
      next_fetch(1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, a);
      checks++; if (a !== 8'h40) begin errors++; $display("FAIL cr_call: got %h want 40", a); end
      next_fetch(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, a);
      checks++; if (a !== (STACK_EN ? 8'h11 : 8'h41)) begin errors++; $display("FAIL cr_ret: got %h want %h", a, STACK_EN ? 8'h11 : 8'h41); end
      checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL cr_stack_err: got %b want 0", stack_err); end
   endtask

   task automatic test_irq();
      logic [7:0] a;
      next_fetch(1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0, a);
      checks++; if (a !== 8'h05) begin errors++; $display("FAIL irq_setup: got %h want 05", a); end
      next_fetch(1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, a);
      checks++; if (a !== 8'hF0) begin errors++; $display("FAIL irq_priority: got %h want f0", a); end
      next_fetch(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, a);
      checks++; if (a !== (STACK_EN ? 8'h06 : 8'hF1)) begin errors++; $display("FAIL irq_ret: got %h want %h", a, STACK_EN ? 8'h06 : 8'hF1); end
   endtask

   task automatic test_stack_overflow();
      logic [7:0] a;
      for (int i = 0; i < 4; i++) begin
         next_fetch(1'b0, 1'b0, 8'h00, 1'b1, 8'h50 + 8'(i), 1'b0, a);
         checks++; if (a !== 8'h50 + 8'(i)) begin errors++; $display("FAIL ovf_call%0d: got %h want %h", i, a, 8'h50 + 8'(i)); end
      end
      checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL ovf_full_no_err: got %b want 0", stack_err); end
      next_fetch(1'b0, 1'b0, 8'h00, 1'b1, 8'h54, 1'b0, a);
      checks++; if (a !== 8'h54) begin errors++; $display("FAIL ovf_call4: got %h want 54", a); end
      checks++; if (stack_err !== STACK_EN) begin errors++; $display("FAIL ovf_err: got %b want %b", stack_err, STACK_EN); end
      next_fetch(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, a);
      checks++; if (a !== (STACK_EN ? 8'h53 : 8'h55)) begin errors++; $display("FAIL ovf_ret_top: got %h want %h", a, STACK_EN ? 8'h53 : 8'h55); end
      repeat (3) next_fetch(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, a);
      next_fetch(1'b0, 1'b1, 8'h20, 1'b0, 8'h00, 1'b0, a);
      checks++; if (a !== 8'h20) begin errors++; $display("FAIL udf_setup: got %h want 20", a); end
      next_fetch(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, a);
      checks++; if (a !== 8'h21) begin errors++; $display("FAIL udf_ret: got %h want 21", a); end
      checks++; if (stack_err !== STACK_EN) begin errors++; $display("FAIL udf_sticky: got %b want %b", stack_err, STACK_EN); end
   endtask

   task automatic test_stall();
      logic [7:0] held, a;
      int         c;
      held = bus.fetch_addr;
      bus.fetch_ready = 1'b0;
      run       = 1'b1;       // ignored outside IDLE/HALT
      jump_req  = 1'b1;       // ignored outside DECIDE
      jump_addr = 8'h99;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++; if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== held) begin
            errors++; $display("FAIL stall_hold%0d: req=%b addr=%h want req=1 addr=%h", i, bus.fetch_req, bus.fetch_addr, held);
         end
      end
      clear_redirects();
      run = 1'b0;
      bus.fetch_ready = 1'b1;
      wait_fetch(a, c);
      checks++; if (a !== held + 8'h01) begin errors++; $display("FAIL stall_next: got %h want %h", a, held + 8'h01); end
   endtask

   task automatic test_halt();
      logic [7:0] a;
      int         c;
      halt_req  = 1'b1;
      jump_req  = 1'b1;
      jump_addr = 8'h30;
      repeat (3) @(posedge clk);
      #1;
      clear_redirects();
      halt_req = 1'b0;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_enter: halted got %b want 1", halted); end
      checks++; if (pc !== 8'h30) begin errors++; $display("FAIL halt_pc: got %h want 30", pc); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (halted !== 1'b1 || bus.fetch_req !== 1'b0) begin
         errors++; $display("FAIL halt_stay: halted=%b req=%b want 1 0", halted, bus.fetch_req);
      end
      run = 1'b1;
      wait_fetch(a, c);
      run = 1'b0;
      checks++; if (a !== 8'h30) begin errors++; $display("FAIL halt_resume: got %h want 30", a); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_leave: halted got %b want 0", halted); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] a;
      int         c;
      bus.rdata_valid = 1'b0;   // park in WAIT
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (pc !== 8'h00) begin errors++; $display("FAIL rstmid_pc: got %h want 00", pc); end
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b want 0", bus.fetch_req); end
      checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b want 0", stack_err); end
      bus.rdata_valid = 1'b1;
      @(posedge clk);
      #3 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL rstmid_idle: req got %b want 0", bus.fetch_req); end
      run = 1'b1;
      wait_fetch(a, c);
      run = 1'b0;
      checks++; if (a !== 8'h00) begin errors++; $display("FAIL rstmid_restart: got %h want 00", a); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wrap();
      test_call_ret();
      test_irq();
      test_stack_overflow();
      test_stall();
      test_halt();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: program-counter and address width in bits.
REQ-002 Parameter DEPTH, default 4: return-stack entries, power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0: PC value loaded at reset.
REQ-004 Parameter IRQ_VEC, default 8'hF0: interrupt target address.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1: rising-edge clock for all state.
REQ-007 Port reset_n, input, 1: asynchronous active-low reset.
REQ-008 Port run, input, 1: leave IDLE or HALT and start fetching.
REQ-009 Port halt_req, input, 1: stop after the current instruction commits.
REQ-010 Port fetch_req, output, 1: fetch request to memory.
REQ-011 Port fetch_addr, output, WIDTH: fetch address; equals pc.
REQ-012 Port fetch_ready, input, 1: memory accepts the request.
REQ-013 Port rdata_valid, input, 1: fetched instruction returned.
REQ-014 Port jump_req, input, 1, and port jump_addr, input, WIDTH: jump redirect.
REQ-015 Port call_req, input, 1, and port call_addr, input, WIDTH: call redirect.
REQ-016 Port ret_req, input, 1: return redirect.
REQ-017 Port irq_req, input, 1: interrupt request.
REQ-018 Port pc, output, WIDTH: current program counter.
REQ-019 Port halted, output, 1: high in HALT.
REQ-020 Port stack_err, output, 1: sticky return-stack overflow/underflow flag.

Function
REQ-021 FSM states: IDLE, FETCH, WAIT, DECIDE, HALT.
- IDLE -> FETCH when run=1.
- FETCH -> WAIT on fetch_req and fetch_ready.
- WAIT -> DECIDE on rdata_valid.
- DECIDE -> HALT if halt_req=1, else -> FETCH.
- HALT -> FETCH when run=1.
REQ-022 fetch_req is high exactly while in FETCH; fetch_addr is held stable until fetch_ready.
REQ-023 Redirect inputs are sampled only in DECIDE; next pc is registered on the DECIDE->next edge.
REQ-024 Redirect priority in DECIDE: irq > jump > call > ret > increment.
REQ-025 Irq: pc <= IRQ_VEC; push pc+1.
REQ-026 Jump: pc <= jump_addr; no push.
REQ-027 Call: pc <= call_addr; push pc+1.
REQ-028 Ret: pc <= top of stack; pop.
REQ-029 Default: pc <= pc+1, modulo 2^WIDTH (all-ones wraps to 0).
REQ-030 Push when stack full: push dropped, stack_err set, redirect still taken.
REQ-031 Ret when stack empty: stack_err set, pc <= pc+1.
REQ-032 stack_err stays set until reset.
REQ-033 halt_req in DECIDE still commits the selected redirect before entering HALT.
REQ-034 Redirect inputs are ignored outside DECIDE.
REQ-035 run is ignored outside IDLE and HALT.
REQ-036 Minimum instruction period is 3 cycles (FETCH, WAIT, DECIDE) with fetch_ready and rdata_valid both immediate.

Reset
REQ-037 While reset_n=0:
- state = IDLE, pc = RESET_PC, stack empty;
- fetch_req, halted and stack_err = 0.
REQ-038 Reset asserted mid-fetch aborts immediately with no pending handshake retained.

Configuration
REQ-039 Macro PC_SEQ_STACK_EN:
- Defined: return stack and stack_err behave per REQ-025 to REQ-032.
- Undefined: no stack storage; call behaves as jump to call_addr; irq jumps to IRQ_VEC without a push; ret is treated as increment; stack_err is tied to 0.

Verification
REQ-040 Reset then run=1, fetch_ready and rdata_valid immediate, no redirects -> fetch_addr 0,1,2,3 at 3-cycle spacing.
REQ-041 At pc=8'hFF, no redirect -> next fetch_addr 8'h00.
REQ-042 pc=8'h10: call_req to 8'h40, then ret_req -> fetch_addr sequence 8'h40, 8'h11; stack_err remains 0.
REQ-043 irq_req and jump_req together in DECIDE at pc=8'h05 -> pc=8'hF0; ret then gives 8'h06.
REQ-044 Five nested calls with DEPTH=4 -> stack_err=1 after the fifth; ret on an empty stack at pc=8'h20 -> pc=8'h21.
REQ-045 Two cases:
- halt_req with jump to 8'h30 -> halted=1, pc=8'h30; run resumes fetching at 8'h30.
- reset_n low during WAIT -> pc=RESET_PC, fetch_req=0.
